mult_ctrl: RTL and testbench

- Sequencing controller for the shared 32-bit radix-4 multiplier unit.
- Accepts one multiply request at a time from the execute stage. Latches and holds the operands, pulses the unit's clear, waits for the unit's ready, captures product and overflow, and holds the response until writeback accepts it.
- Also provides zero-operand short-circuit, a watchdog timeout and pipeline flush.

---
 rtl/mult_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mult_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencing controller for the shared 32-bit radix-4 multiplier unit.
// Holds one request's operands, runs the unit under a watchdog, and returns the result with a valid/ready handshake.
module mult_ctrl #(
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_overflow,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_timeout,
    output logic             busy,
    output logic             mul_rst,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_ready,
    input  logic [31:0]      mul_out,
    input  logic             mul_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               resp_overflow_q, resp_overflow_d;
    logic               resp_timeout_q, resp_timeout_d;
    logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
    logic               resp_valid_q, resp_valid_d;

    logic               accept;
    logic               zero_op;

    assign req_ready     = (state_q == IDLE) && !flush;
    assign busy          = (state_q != IDLE);
    // The unit is only released from clear while actually computing.
    assign mul_rst       = (state_q != RUN);
    assign mul_a         = a_q;
    assign mul_b         = b_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_timeout  = resp_timeout_q;
    assign resp_tag      = resp_tag_q;

    assign accept  = req_valid && req_ready;
    assign zero_op = (req_a == 32'd0) || (req_b == 32'd0);

    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        tag_d           = tag_q;
        cnt_d           = cnt_q;
        resp_data_d     = resp_data_q;
        resp_overflow_d = resp_overflow_q;
        resp_timeout_d  = resp_timeout_q;
        resp_tag_d      = resp_tag_q;
        resp_valid_d    = resp_valid_q;

        if (flush) begin
            state_d        = IDLE;
            resp_valid_d   = 1'b0;
            resp_timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_d   = req_a;
                        b_d   = req_b;
                        tag_d = req_tag;
                        if (zero_op) begin
                            // Product is trivially zero; answer without waking the unit.
                            resp_data_d     = 32'd0;
                            resp_overflow_d = 1'b0;
                            resp_timeout_d  = 1'b0;
                            resp_tag_d      = req_tag;
                            resp_valid_d    = 1'b1;
                            state_d         = DONE;
                        end else begin
                            state_d = CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (mul_ready) begin
                        resp_data_d     = mul_out;
                        resp_overflow_d = mul_overflow;
                        resp_timeout_d  = 1'b0;
                        resp_tag_d      = tag_q;
                        resp_valid_d    = 1'b1;
                        state_d         = DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        resp_data_d     = 32'd0;
                        resp_overflow_d = 1'b0;
                        resp_timeout_d  = 1'b1;
                        resp_tag_d      = tag_q;
                        resp_valid_d    = 1'b1;
                        state_d         = DONE;
                    end
                end
                DONE: begin
                    if (resp_valid_q && resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            tag_q           <= '0;
            cnt_q           <= '0;
            resp_data_q     <= '0;
            resp_overflow_q <= 1'b0;
            resp_timeout_q  <= 1'b0;
            resp_tag_q      <= '0;
            resp_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            tag_q           <= tag_d;
            cnt_q           <= cnt_d;
            resp_data_q     <= resp_data_d;
            resp_overflow_q <= resp_overflow_d;
            resp_timeout_q  <= resp_timeout_d;
            resp_tag_q      <= resp_tag_d;
            resp_valid_q    <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Testbench for mult_ctrl: emulates the multiplier unit with a programmable latency and
// checks every response against an arithmetic reference of the signed 32-bit product.
module tb_mult_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_overflow, resp_timeout;
    logic [4:0]  resp_tag;
    logic        busy, mul_rst;
    logic [31:0] mul_a, mul_b;
    logic        mul_ready;
    logic [31:0] mul_out;
    logic        mul_overflow;

    int checks   = 0;
    int failures = 0;

    // unit emulation: ready in RUN cycle stub_lat (1-based), garbage outputs otherwise
    int          stub_lat = 19;
    bit          stub_en  = 1'b1;
    int          unit_cnt = 0;
    logic [32:0] unit_res;

    always #5 clk = ~clk;

    mult_ctrl #(.CNT_W(6), .TIMEOUT(TIMEOUT), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_overflow(resp_overflow),
        .resp_tag(resp_tag), .resp_timeout(resp_timeout),
        .busy(busy), .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_out(mul_out), .mul_overflow(mul_overflow)
    );

    // {overflow, low 32 bits} of the signed 32x32 product
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint lo_ext;
        p      = longint'($signed(a)) * longint'($signed(b));
        lo_ext = longint'($signed(p[31:0]));
        return {(p != lo_ext), p[31:0]};
    endfunction

    always @(posedge clk) begin
        if (mul_rst) unit_cnt <= 0;
        else         unit_cnt <= unit_cnt + 1;
    end

    assign unit_res     = ref_mul(mul_a, mul_b);
    assign mul_ready    = stub_en && !mul_rst && (unit_cnt == stub_lat - 1);
    assign mul_out      = mul_ready ? unit_res[31:0] : 32'hDEAD_BEEF;
    assign mul_overflow = mul_ready ? unit_res[32] : 1'b1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return 32'd0;
        if (sel == 1) return 32'($urandom_range(0, 200)) - 32'd100;
        return $urandom;
    endfunction

    // One full transaction starting at a negedge with the controller idle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                         input int lat, input bit en, input int hold);
        logic [32:0] r;
        logic [31:0] exp_data;
        logic        exp_ovf, exp_to;
        int          exp_lat, n;
        bit          zero;
        zero = (a == 0) || (b == 0);
        r    = ref_mul(a, b);
        if (zero) begin
            exp_lat = 1; exp_data = 0; exp_ovf = 0; exp_to = 0;
        end else if (en && lat >= 1 && lat <= TIMEOUT) begin
            exp_lat = lat + 2; exp_data = r[31:0]; exp_ovf = r[32]; exp_to = 0;
        end else begin
            exp_lat = TIMEOUT + 2; exp_data = 0; exp_ovf = 0; exp_to = 1;
        end

        stub_lat   = lat;
        stub_en    = en;
        resp_ready = (hold == 0);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_a = a; req_b = b; req_tag = tag;
        @(negedge clk);
        req_valid = 0; req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom);
        n = 1;
        while (!resp_valid && n < 100) begin
            check("busy_inflight", busy, 1);
            check("req_ready_inflight", req_ready, 0);
            check("mul_a_hold", mul_a, a);
            check("mul_b_hold", mul_b, b);
            @(negedge clk);
            n++;
        end
        check("resp_wait", resp_valid, 1);
        check("latency", n, exp_lat);
        check("resp_data", resp_data, exp_data);
        check("resp_overflow", resp_overflow, exp_ovf);
        check("resp_timeout", resp_timeout, exp_to);
        check("resp_tag", resp_tag, tag);
        check("mul_rst_done", mul_rst, 1);
        $display("op a=0x%08h b=0x%08h tag=%0d lat=%0d -> data=0x%08h ovf=%0d to=%0d cycles=%0d",
                 a, b, tag, lat, resp_data, resp_overflow, resp_timeout, n);

        // A competing request stays pending through the handshake and must not be taken.
        req_valid = 1; req_a = 32'd3; req_b = 32'd5;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_data", resp_data, exp_data);
            check("bp_timeout", resp_timeout, exp_to);
            check("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1;
        @(negedge clk);
        check("handshake_valid", resp_valid, 0);
        check("handshake_busy", busy, 0);
        check("handshake_req_ready", req_ready, 1);
        req_valid  = 0;
        resp_ready = 0;
    endtask

    // Start a non-zero op, hit it with flush or rst on the 5th RUN cycle.
    task automatic abort_op(input bit use_rst);
        int seen;
        stub_lat = 19; stub_en = 1; resp_ready = 1;
        req_valid = 1; req_a = 32'd1234; req_b = 32'd77; req_tag = 5'd9;
        @(negedge clk);
        req_valid = 0;
        repeat (5) @(negedge clk);
        check("abort_in_run", mul_rst, 0);
        if (use_rst) rst = 1; else flush = 1;
        check("abort_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 0; flush = 0;
        check("abort_busy", busy, 0);
        check("abort_mul_rst", mul_rst, 1);
        check("abort_valid", resp_valid, 0);
        check("abort_timeout", resp_timeout, 0);
        if (use_rst) begin
            check("rst_resp_data", resp_data, 0);
            check("rst_resp_tag", resp_tag, 0);
            check("rst_mul_a", mul_a, 0);
        end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 0);
        $display("abort via %s: dropped, idle", use_rst ? "rst" : "flush");
        do_op(32'd6, 32'd7, 5'd3, 19, 1, 0);
    endtask

    initial begin
        int seen;
        rst = 1; flush = 0; req_valid = 0; req_a = 0; req_b = 0; req_tag = 0; resp_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mul_rst", mul_rst, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_data", resp_data, 0);
        check("rst_ovf", resp_overflow, 0);
        check("rst_to", resp_timeout, 0);
        check("rst_tag", resp_tag, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        $display("reset state checked");

        do_op(32'd7, 32'hFFFF_FFFD, 5'd5, 19, 1, 0);
        check("pos_neg_data", resp_data, 32'hFFFF_FFEB);
        do_op(32'h0001_0000, 32'h0001_0000, 5'd17, 19, 1, 0);
        check("ovf_flag_kept", resp_overflow, 1);
        do_op(32'd0, 32'h1234, 5'd2, 19, 1, 0);
        do_op(32'h0012_3456, 32'h0000_0789, 5'd11, 19, 1, 10);
        do_op(32'd12345, 32'd678, 5'd30, 0, 0, 0);
        do_op(32'd12345, 32'd678, 5'd31, TIMEOUT, 1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1, 1, 2);

        for (int i = 0; i < 12; i++)
            do_op(rand_operand(), rand_operand(), 5'($urandom), $urandom_range(1, 30), 1,
                  $urandom_range(0, 3));

        abort_op(0);
        abort_op(1);

        // flush while a response is pending in DONE, with a request also offered
        stub_lat = 10; stub_en = 1; resp_ready = 0;
        req_valid = 1; req_a = 32'd100; req_b = 32'd200; req_tag = 5'd7;
        @(negedge clk);
        req_valid = 0;
        seen = 0;
        while (!resp_valid && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        check("done_pending", resp_valid, 1);
        flush = 1; req_valid = 1; req_a = 32'd9; req_b = 32'd9;
        check("flush_req_ready", req_ready, 0);
        @(negedge clk);
        flush = 0; req_valid = 0;
        check("flush_done_valid", resp_valid, 0);
        check("flush_done_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("flush_done_quiet", resp_valid, 0);
        $display("flush in DONE: pending response dropped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
